// File: rtl/path_capture_monitor.sv
// Purpose: at-speed path monitor. Drives a pseudo-random pattern into an external
//          launch flop and counts per-path mismatches on the captured taps.
// Latency: start -> 2 PRIME cycles -> 'cycles' RUN cycles -> 1-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE and is otherwise dropped.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request a run; cycles is sampled when start is accepted
//   launch_q  : pattern bit for the external launch flop D input
//   tap_d     : Q of each capture flop at the end of its delay path
//   busy/done : run in progress / one-cycle end-of-run pulse
//   fail      : sticky per-path mismatch flags
//   err_cnt   : per-path saturating mismatch counters, path i at [i*CNT_W +: CNT_W]
module path_capture_monitor #(
    parameter int          NTAP  = 5,
    parameter int          CNT_W = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           cycles,
    output logic                  launch_q,
    input  logic [NTAP-1:0]       tap_d,
    output logic                  busy,
    output logic                  done,
    output logic [NTAP-1:0]       fail,
    output logic [NTAP*CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic        prime_ph;   // 0 in first PRIME cycle, 1 in second
    logic [15:0] lfsr;
    logic [15:0] rem;
    logic [1:0]  hist;       // hist[0] = launch_q one cycle ago, hist[1] = two cycles ago
    logic [15:0] lfsr_step;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right, output at bit 0
    assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Outputs are registered with the value they must have in the next state,
    // so launch_q tracks lfsr[0] during PRIME/RUN without any decode logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prime_ph <= 1'b0;
            lfsr     <= SEED;
            rem      <= '0;
            hist     <= '0;
            launch_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= '0;
            err_cnt  <= '0;
        end else begin
            // Launch-to-capture is one launch edge plus a single-cycle path
            hist <= {hist[0], launch_q};

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PRIME;
                        prime_ph <= 1'b0;
                        lfsr     <= SEED;
                        rem      <= cycles;
                        fail     <= '0;
                        err_cnt  <= '0;
                        launch_q <= SEED[0];
                        busy     <= 1'b1;
                    end
                end

                PRIME: begin
                    lfsr <= lfsr_step;
                    if (!prime_ph) begin
                        prime_ph <= 1'b1;
                        launch_q <= lfsr_step[0];
                    end else if (rem == 16'd0) begin
                        state    <= DONE;
                        launch_q <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state    <= RUN;
                        launch_q <= lfsr_step[0];
                    end
                end

                RUN: begin
                    lfsr <= lfsr_step;
                    rem  <= rem - 16'd1;
                    for (int i = 0; i < NTAP; i++) begin
                        if (tap_d[i] != hist[1]) begin
                            fail[i] <= 1'b1;
                            if (err_cnt[i*CNT_W +: CNT_W] != CNT_MAX)
                                err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + CNT_ONE;
                        end
                    end
                    if (rem == 16'd1) begin
                        state    <= DONE;
                        launch_q <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        launch_q <= lfsr_step[0];
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    launch_q <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_capture_monitor.sv
module tb_path_capture_monitor;

    localparam int          NTAP  = 5;
    localparam int          CNT_W = 8;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          MAXC  = 1024;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [15:0]           cycles;
    logic                  launch_q;
    logic [NTAP-1:0]       tap_d;
    logic                  busy;
    logic                  done;
    logic [NTAP-1:0]       fail;
    logic [NTAP*CNT_W-1:0] err_cnt;

    path_capture_monitor #(.NTAP(NTAP), .CNT_W(CNT_W), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .cycles(cycles),
        .launch_q(launch_q), .tap_d(tap_d), .busy(busy), .done(done),
        .fail(fail), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference pattern: output bit stream of the LFSR, from its linear recurrence
    bit              s_seq [0:MAXC+63];
    bit              lq    [0:MAXC-1];   // observed launch_q per cycle of a run
    logic [NTAP-1:0] tp    [0:MAXC-1];   // tap_d applied per cycle of a run

    typedef struct {
        int              n;
        int              mode;       // 0 loopback, 1 slip on path 2, 2 invert path 0, 3 random
        int              restart;    // 0 none, 1 start 10 cycles in, 2 start during done
        logic [NTAP-1:0] exp_fail;
        bit              use_ef;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_seq();
        logic [15:0] sd;
        sd = SEED;
        for (int j = 0; j < 16; j++) s_seq[j] = sd[j];
        for (int j = 16; j < MAXC + 64; j++)
            s_seq[j] = s_seq[j-16] ^ s_seq[j-14] ^ s_seq[j-13] ^ s_seq[j-11];
    endfunction

    // Models the external launch flop followed by capture flops with various delays
    function automatic logic [NTAP-1:0] tap_for(input int mode, input int j);
        logic [NTAP-1:0] t;
        bit p2, p3;
        p2 = (j >= 2) ? lq[j-2] : 1'b0;
        p3 = (j >= 3) ? lq[j-3] : 1'b0;
        t  = {NTAP{p2}};
        case (mode)
            1:       t[2] = p3;
            2:       t[0] = ~p2;
            3:       t = NTAP'($urandom);
            default: ;
        endcase
        return t;
    endfunction

    task automatic do_run(input int n, input int mode, input int restart,
                          input logic [NTAP-1:0] exp_fail, input bit use_ef, input string tag);
        int done_at, busy_cnt, lmis, lim;
        int expc [NTAP];
        logic [NTAP-1:0]       expf;
        logic [NTAP*CNT_W-1:0] expv;

        done_at  = -1;
        busy_cnt = 0;
        cycles   = 16'(n);
        tap_d    = NTAP'($urandom);
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int j = 0; j < n + 10; j++) begin
            lq[j] = launch_q;
            if (done) begin
                done_at = j;
                break;
            end
            if (busy) busy_cnt++;
            tap_d = tap_for(mode, j);
            tp[j] = tap_d;
            if (restart == 1) start = (j == 10);
            step();
        end
        start = 1'b0;

        // Expected results from the pattern stream and the taps actually applied
        expf = '0;
        for (int i = 0; i < NTAP; i++) expc[i] = 0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < NTAP; i++)
                if (tp[k+2][i] != s_seq[k]) begin
                    expf[i] = 1'b1;
                    if (expc[i] < (1 << CNT_W) - 1) expc[i]++;
                end
        expv = '0;
        for (int i = 0; i < NTAP; i++) expv[i*CNT_W +: CNT_W] = CNT_W'(expc[i]);

        lmis = 0;
        lim  = (done_at >= 0) ? done_at : n + 2;
        for (int j = 0; j < lim && j < n + 2; j++)
            if (lq[j] != s_seq[j]) lmis++;

        chk({tag, "_done_seen"}, 64'(done_at >= 0), 64'd1);
        chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(n + 2));
        chk({tag, "_done_at"}, 64'(done_at), 64'(n + 2));
        chk({tag, "_launch_seq_mismatches"}, 64'(lmis), 64'd0);
        chk({tag, "_launch_in_done"}, 64'(launch_q), 64'd0);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        for (int i = 0; i < NTAP; i++)
            chk($sformatf("%s_err_cnt%0d", tag, i), 64'(err_cnt[i*CNT_W +: CNT_W]), 64'(expc[i]));
        chk({tag, "_fail_model"}, 64'(fail), 64'(expf));
        if (use_ef) chk({tag, "_fail_const"}, 64'(fail), 64'(exp_fail));

        if (restart == 2) start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_no_second_done"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        step();
        chk({tag, "_idle_busy2"}, 64'(busy), 64'd0);
        chk({tag, "_idle_done2"}, 64'(done), 64'd0);
        chk({tag, "_hold_err_cnt"}, 64'(err_cnt), 64'(expv));
        chk({tag, "_hold_fail"}, 64'(fail), 64'(expf));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_seq();
        tbl[0] = '{100, 0, 0, 5'b00000, 1'b1};  // loopback
        tbl[1] = '{200, 1, 0, 5'b00100, 1'b1};  // one-path slip
        tbl[2] = '{300, 2, 0, 5'b00001, 1'b1};  // saturation
        tbl[3] = '{0,   3, 0, 5'b00000, 1'b1};  // zero-length, random taps
        tbl[4] = '{50,  0, 1, 5'b00000, 1'b1};  // start while busy
        tbl[5] = '{20,  3, 2, 5'b00000, 1'b0};  // random taps, start during done
        tbl[6] = '{1,   2, 0, 5'b00001, 1'b1};  // single compare cycle

        rst = 1'b0; start = 1'b0; cycles = '0; tap_d = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_launch_q", 64'(launch_q), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();

        for (int t = 0; t < 7; t++) begin
            do_run(tbl[t].n, tbl[t].mode, tbl[t].restart, tbl[t].exp_fail, tbl[t].use_ef,
                   $sformatf("vec%0d", t));
            if (t == 1) chk("slip_cnt2_nonzero", 64'(err_cnt[2*CNT_W +: CNT_W] != 0), 64'd1);
            if (t == 2) chk("sat_cnt0", 64'(err_cnt[CNT_W-1:0]), 64'd255);
        end

        for (int r = 0; r < 6; r++)
            do_run($urandom_range(0, 80), $urandom_range(0, 3), 0, '0, 1'b0,
                   $sformatf("rnd%0d", r));

        // Mid-run asynchronous reset
        cycles = 16'd100;
        tap_d  = '1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (22) step();
        chk("mr_busy_before", 64'(busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("mr_launch_q", 64'(launch_q), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_fail", 64'(fail), 64'd0);
        chk("mr_err_cnt", 64'(err_cnt), 64'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("mr_no_done_%0d", c), 64'(done), 64'd0);
            chk($sformatf("mr_idle_%0d", c), 64'(busy), 64'd0);
        end
        do_run(30, 0, 0, 5'b00000, 1'b1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
